// File: rtl/mycpu_pkg.sv
// Shared CPU types.
// Contents:
//   pc_t           - PC step code driven by fetch into the PC register.
//   ifetch_state_t - fetch stage FSM states.
//   REDIR_BRA/JMP  - encodings of redir_kind.
package mycpu_pkg;

  typedef enum logic [1:0] {
    PC_NOP = 2'd0,
    PC_INC = 2'd1,
    PC_BRA = 2'd2,
    PC_JMP = 2'd3
  } pc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } ifetch_state_t;

  localparam logic REDIR_BRA = 1'b0;
  localparam logic REDIR_JMP = 1'b1;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle.
// Carries the instruction memory req/ack channel and the instruction
// register valid/ready channel to decode.
//   master - fetch stage side (drives req/addr and the IR outputs)
//   slave  - memory/decode side
interface ifetch_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
    input  imem_ack, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
    output imem_ack, imem_rdata, ir_ready
  );

endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage, upstream of the PC register.
// Fetches the word at pc_in over a req/ack memory handshake, holds it in
// the instruction register and offers it to decode with valid/ready.
// Drives the PC step code every cycle: INC on an accepted fetch,
// BRA/JMP on a redirect from execute, NOP otherwise.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_in               current PC
//   ps_out              PC step code (pc_t)
//   ia_out / ra_out     branch offset / jump target to the PC
//   redir_*             single-cycle redirect request from execute
//   fetch_err           sticky fetch timeout flag
//   bus (master)        imem_req/addr/ack/rdata and ir_valid/data/pc/ready
//
// Build option: IFETCH_TIMEOUT_EN enables the imem_ack wait counter
// (limit TIMEOUT cycles) and the ERR state. Without it the stage waits
// forever for ack and fetch_err is tied low.
//
// state | meaning
// IDLE  | one cycle after reset before the first fetch
// REQ   | request outstanding at pc_in
// HOLD  | IR holds a valid word for decode
// DRAIN | request outstanding for a squashed fetch, data will be dropped
// ERR   | ack timeout, exits only by reset
module ifetch
  import mycpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   pc_in,
  output pc_t           ps_out,
  output logic [15:0]   ia_out,
  output logic [15:0]   ra_out,
  input  logic          redir_valid,
  input  logic          redir_kind,
  input  logic [15:0]   redir_off,
  input  logic [15:0]   redir_tgt,
  output logic          fetch_err,
  ifetch_if.master      bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ifetch: TIMEOUT must be at least 1");
  end

  ifetch_state_t state_q, state_d;
  logic [15:0]   ir_data_q, ir_data_d;
  logic [15:0]   ir_pc_q, ir_pc_d;
  pc_t           redir_ps;
  logic          timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting     = ((state_q == REQ) || (state_q == DRAIN)) && !bus.imem_ack;
  assign cnt_d       = waiting ? cnt_q + CW'(1) : '0;
  // Reaching TIMEOUT happens on the edge where cnt_q would step to it.
  assign timeout_hit = waiting && (cnt_q == CW'(TIMEOUT - 1));
  assign fetch_err   = (state_q == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  assign redir_ps = (redir_kind == REDIR_JMP) ? PC_JMP : PC_BRA;

  always_comb begin
    state_d   = state_q;
    ps_out    = PC_NOP;
    ir_data_d = ir_data_q;
    ir_pc_d   = ir_pc_q;

    case (state_q)
      IDLE: begin
        if (redir_valid) ps_out = redir_ps;
        state_d = REQ;
      end
      REQ: begin
        if (redir_valid) begin
          ps_out = redir_ps;
          // Without ack the request must stay up until memory answers.
          state_d = bus.imem_ack ? REQ : DRAIN;
        end else if (bus.imem_ack) begin
          ps_out    = PC_INC;
          ir_data_d = bus.imem_rdata;
          ir_pc_d   = pc_in;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redir_valid) begin
          ps_out  = redir_ps;
          state_d = REQ;
        end else if (bus.ir_ready) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redir_valid) ps_out = redir_ps;
        if (bus.imem_ack) state_d = REQ;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) state_d = ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_data_q <= '0;
      ir_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_data_q <= ir_data_d;
      ir_pc_q   <= ir_pc_d;
    end
  end

  assign ia_out        = redir_off;
  assign ra_out        = redir_tgt;
  assign bus.imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign bus.imem_addr = pc_in;
  assign bus.ir_valid  = (state_q == HOLD);
  assign bus.ir_data   = ir_data_q;
  assign bus.ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  import mycpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  pc_t         ps_out;
  logic [15:0] ia_out;
  logic [15:0] ra_out;
  logic        redir_valid;
  logic        redir_kind;
  logic [15:0] redir_off;
  logic [15:0] redir_tgt;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  ifetch_if bus ();

  ifetch #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc),
    .ps_out      (ps_out),
    .ia_out      (ia_out),
    .ra_out      (ra_out),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .redir_off   (redir_off),
    .redir_tgt   (redir_tgt),
    .fetch_err   (fetch_err),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register model downstream of the fetch stage.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 16'h0000;
    else begin
      case (ps_out)
        PC_INC:  pc <= pc + 16'd1;
        PC_BRA:  pc <= pc + ia_out;
        PC_JMP:  pc <= ra_out;
        default: pc <= pc;
      endcase
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    redir_valid     = 1'b0;
    redir_kind      = 1'b0;
    redir_off       = 16'h0;
    redir_tgt       = 16'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.ir_ready    = 1'b0;

    #2;
    check("rst_req",      16'(bus.imem_req), 16'h0);
    check("rst_ir_valid", 16'(bus.ir_valid), 16'h0);
    check("rst_ir_data",  bus.ir_data,       16'h0);
    check("rst_ir_pc",    bus.ir_pc,         16'h0);
    check("rst_err",      16'(fetch_err),    16'h0);
    check("rst_ps",       16'(ps_out),       16'(PC_NOP));

    // First fetch, ack two cycles after req.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("f0_req",  16'(bus.imem_req), 16'h1);
    check("f0_addr", bus.imem_addr,     16'h0000);
    check("f0_ps",   16'(ps_out),       16'(PC_NOP));
    @(negedge clk); #1;
    check("f0_req_hold", 16'(bus.imem_req), 16'h1);
    @(negedge clk);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234; #1;
    check("f0_ps_inc", 16'(ps_out), 16'(PC_INC));
    @(negedge clk);
    bus.imem_ack = 1'b0; #1;
    check("f0_valid", 16'(bus.ir_valid), 16'h1);
    check("f0_data",  bus.ir_data,       16'h1234);
    check("f0_pc",    bus.ir_pc,         16'h0000);
    check("f0_noreq", 16'(bus.imem_req), 16'h0);

    // Decode stalls five cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_valid", 16'(bus.ir_valid), 16'h1);
      check("stall_data",  bus.ir_data,       16'h1234);
      check("stall_ps",    16'(ps_out),       16'(PC_NOP));
      check("stall_req",   16'(bus.imem_req), 16'h0);
    end
    @(negedge clk); bus.ir_ready = 1'b1;
    @(negedge clk); bus.ir_ready = 1'b0; #1;
    check("f1_req",   16'(bus.imem_req), 16'h1);
    check("f1_addr",  bus.imem_addr,     16'h0001);
    check("f1_valid", 16'(bus.ir_valid), 16'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5678; #1;
    check("f1_ps_inc", 16'(ps_out), 16'(PC_INC));
    @(negedge clk); bus.imem_ack = 1'b0; #1;
    check("f1_valid2", 16'(bus.ir_valid), 16'h1);
    check("f1_data",   bus.ir_data,       16'h5678);
    check("f1_pc",     bus.ir_pc,         16'h0001);

    // Jump while holding, with decode accepting in the same cycle.
    redir_valid = 1'b1; redir_kind = REDIR_JMP; redir_tgt = 16'h0040; bus.ir_ready = 1'b1; #1;
    check("jmp_ps", 16'(ps_out), 16'(PC_JMP));
    check("jmp_ra", ra_out,      16'h0040);
    @(negedge clk);
    redir_valid = 1'b0; bus.ir_ready = 1'b0; #1;
    check("jmp_valid", 16'(bus.ir_valid), 16'h0);
    check("jmp_req",   16'(bus.imem_req), 16'h1);
    check("jmp_addr",  bus.imem_addr,     16'h0040);

    // Branch while a request is outstanding without ack.
    redir_valid = 1'b1; redir_kind = REDIR_BRA; redir_off = 16'hFFFE; #1;
    check("bra_ps", 16'(ps_out), 16'(PC_BRA));
    check("bra_ia", ia_out,      16'hFFFE);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("drain_req",   16'(bus.imem_req), 16'h1);
    check("drain_valid", 16'(bus.ir_valid), 16'h0);
    @(negedge clk);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF; #1;
    check("drain_ps", 16'(ps_out), 16'(PC_NOP));
    @(negedge clk); bus.imem_ack = 1'b0; #1;
    check("drop_valid", 16'(bus.ir_valid), 16'h0);
    check("drop_data",  bus.ir_data,       16'h5678);
    check("f2_req",     16'(bus.imem_req), 16'h1);
    check("f2_addr",    bus.imem_addr,     16'h003E);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h9ABC; #1;
    check("f2_ps_inc", 16'(ps_out), 16'(PC_INC));
    @(negedge clk); bus.imem_ack = 1'b0; #1;
    check("f2_valid", 16'(bus.ir_valid), 16'h1);
    check("f2_data",  bus.ir_data,       16'h9ABC);
    check("f2_pc",    bus.ir_pc,         16'h003E);

    // Redirect coinciding with ack: data dropped, refetch at target.
    bus.ir_ready = 1'b1;
    @(negedge clk); bus.ir_ready = 1'b0; #1;
    check("f3_addr", bus.imem_addr, 16'h003F);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    redir_valid = 1'b1; redir_kind = REDIR_JMP; redir_tgt = 16'h0100; #1;
    check("ackjmp_ps", 16'(ps_out), 16'(PC_JMP));
    @(negedge clk);
    bus.imem_ack = 1'b0; redir_valid = 1'b0; #1;
    check("ackjmp_valid", 16'(bus.ir_valid), 16'h0);
    check("ackjmp_data",  bus.ir_data,       16'h9ABC);
    check("ackjmp_req",   16'(bus.imem_req), 16'h1);
    check("ackjmp_addr",  bus.imem_addr,     16'h0100);

    // ir_ready with no valid word is ignored.
    bus.ir_ready = 1'b1; #1;
    check("stray_ready_ps", 16'(ps_out), 16'(PC_NOP));
    @(negedge clk); bus.ir_ready = 1'b0; #1;
    check("stray_ready_req",   16'(bus.imem_req), 16'h1);
    check("stray_ready_valid", 16'(bus.ir_valid), 16'h0);

    // Asynchronous reset in the middle of a request.
    #2; rst_n = 1'b0; #1;
    check("mid_rst_req",   16'(bus.imem_req), 16'h0);
    check("mid_rst_valid", 16'(bus.ir_valid), 16'h0);
    check("mid_rst_data",  bus.ir_data,       16'h0);
    check("mid_rst_err",   16'(fetch_err),    16'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("restart_idle_req", 16'(bus.imem_req), 16'h0);
    @(negedge clk); #1;
    check("restart_req",  16'(bus.imem_req), 16'h1);
    check("restart_addr", bus.imem_addr,     16'h0000);

`ifdef IFETCH_TIMEOUT_EN
    repeat (3) @(negedge clk);
    #1;
    check("to_not_yet", 16'(fetch_err),    16'h0);
    check("to_req_up",  16'(bus.imem_req), 16'h1);
    @(negedge clk); #1;
    check("to_err",   16'(fetch_err),    16'h1);
    check("to_noreq", 16'(bus.imem_req), 16'h0);
    check("to_valid", 16'(bus.ir_valid), 16'h0);
    redir_valid = 1'b1; redir_kind = REDIR_JMP; redir_tgt = 16'h0200; #1;
    check("to_redir_ps", 16'(ps_out), 16'(PC_NOP));
    @(negedge clk); redir_valid = 1'b0; #1;
    check("to_sticky", 16'(fetch_err), 16'h1);
    rst_n = 1'b0; #1;
    check("to_rst_clear", 16'(fetch_err), 16'h0);
    @(negedge clk); rst_n = 1'b1;
`else
    repeat (20) @(negedge clk);
    #1;
    check("wait_no_err", 16'(fetch_err),    16'h0);
    check("wait_req",    16'(bus.imem_req), 16'h1);
    check("wait_addr",   bus.imem_addr,     16'h0000);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
